instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// =============================================================================
// Module : instr_encoder_if
// Request/response bundle between an instruction producer and instr_encoder.
// Rev    : 1.0
// =============================================================================
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
    logic        full;

    modport master (
        output in_valid, in_kind, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, addr, err, full
    );

    modport slave (
        input  in_valid, in_kind, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, addr, err, full
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// =============================================================================
// Module : instr_encoder
// Encodes LD/SD/ADD/SUB/AND/OR/BEQ requests into RV64 words at sequential addresses.
// Rev    : 1.0
// =============================================================================
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      flush,
    instr_encoder_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(MAX_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0] CAP_IDX  = IDX_W'(MAX_WORDS);

    localparam logic [2:0] K_LD  = 3'd0;
    localparam logic [2:0] K_SD  = 3'd1;
    localparam logic [2:0] K_ADD = 3'd2;
    localparam logic [2:0] K_SUB = 3'd3;
    localparam logic [2:0] K_AND = 3'd4;
    localparam logic [2:0] K_OR  = 3'd5;
    localparam logic [2:0] K_BEQ = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [31:0]        r_instr;
    logic [31:0]        w_word;
    logic [63:0]        r_addr;
    logic [63:0]        w_addr_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_legal;
    logic               w_out_valid;
    logic               w_full;
    logic               w_handoff;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic signed [63:0] w_simm;

    assign w_simm      = $signed(bus.imm);
    assign w_out_valid = (r_state == ST_HOLD);
    assign w_full      = (r_state == ST_DONE);
    assign w_handoff   = w_out_valid && bus.out_ready;
    assign w_idx_inc   = r_idx + IDX_W'(1);

    // r_run keeps in_ready low until the first clock edge after reset release.
    // The last-word term stops a final handoff from coinciding with a new accept.
    assign w_in_ready = r_run && (!w_out_valid || bus.out_ready) && !w_full && !flush
                        && !(w_out_valid && (r_idx == LAST_IDX));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = w_accept && w_legal;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b0;
        case (bus.in_kind)
            K_LD: begin
                w_legal = (w_simm >= -64'sd2048) && (w_simm <= 64'sd2047);
                w_word  = {bus.imm[11:0], bus.rs1, 3'b011, bus.rd, OP_LOAD};
            end
            K_SD: begin
                w_legal = (w_simm >= -64'sd2048) && (w_simm <= 64'sd2047);
                w_word  = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b011, bus.imm[4:0], OP_STORE};
            end
            K_ADD: begin
                w_legal = 1'b1;
                w_word  = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, OP_REG};
            end
            K_SUB: begin
                w_legal = 1'b1;
                w_word  = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, OP_REG};
            end
            K_AND: begin
                w_legal = 1'b1;
                w_word  = {7'b0000000, bus.rs2, bus.rs1, 3'b111, bus.rd, OP_REG};
            end
            K_OR: begin
                w_legal = 1'b1;
                w_word  = {7'b0000000, bus.rs2, bus.rs1, 3'b110, bus.rd, OP_REG};
            end
            K_BEQ: begin
                w_legal = (w_simm >= -64'sd4096) && (w_simm <= 64'sd4094) && !bus.imm[0];
                w_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                           bus.imm[4:1], bus.imm[11], OP_BRANCH};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = 32'h0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_idx_nxt   = '0;
        end else begin
            w_err_nxt = w_accept && !w_legal;
            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_handoff) begin
                        w_idx_nxt = w_idx_inc;
                        if (w_idx_inc == CAP_IDX) begin
                            w_state_nxt = ST_DONE;
                        end else if (!w_load) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // A word accepted alongside a handoff takes the slot after the departing one.
    assign w_addr_nxt = BASE_ADDR + 64'({w_idx_nxt, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_run   <= 1'b0;
            r_idx   <= '0;
            r_instr <= 32'h0;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            if (flush) begin
                r_addr <= BASE_ADDR;
            end else if (w_load) begin
                r_instr <= w_word;
                r_addr  <= w_addr_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.instr     = r_instr;
    assign bus.addr      = r_addr;
    assign bus.err       = r_err;
    assign bus.full      = w_full;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// Bench for instr_encoder: directed scenarios on two instances plus a randomized
// run checked against a behavioural model of the encoding and handshake rules.
module tb_instr_encoder;
    localparam int          MAXW  = 256;
    localparam logic [63:0] SBASE = 64'h1000;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic flush   = 1'b0;
    logic flush_s = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        m_valid;
    logic        m_err;
    logic        m_full;
    int          m_cnt;
    logic [31:0] m_instr;
    logic [63:0] m_addr;

    instr_encoder_if bus ();
    instr_encoder_if sbus ();

    instr_encoder dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
    instr_encoder #(.BASE_ADDR(SBASE), .MAX_WORDS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush_s), .bus(sbus));

    always #5 clk = ~clk;

    // Returns {legal, word} computed from the field layouts with plain arithmetic.
    function automatic logic [32:0] ref_encode(input logic [2:0] k, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [63:0] im);
        longint      s;
        logic [63:0] t;
        logic [63:0] f3;
        logic [63:0] f7;
        logic        ok;
        s  = longint'(im);
        t  = 64'h0;
        f3 = 64'd0;
        f7 = 64'd0;
        ok = 1'b1;
        case (k)
            3'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                t  = ((im & 64'hFFF) << 20) | (64'(s1) << 15) | (64'd3 << 12) | (64'(d) << 7) | 64'h03;
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                t  = (((im >> 5) & 64'h7F) << 25) | (64'(s2) << 20) | (64'(s1) << 15)
                   | (64'd3 << 12) | ((im & 64'h1F) << 7) | 64'h23;
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                if (k == 3'd3) f7 = 64'h20;
                if (k == 3'd4) f3 = 64'd7;
                if (k == 3'd5) f3 = 64'd6;
                t = (f7 << 25) | (64'(s2) << 20) | (64'(s1) << 15) | (f3 << 12) | (64'(d) << 7) | 64'h33;
            end
            3'd6: begin
                ok = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
                t  = (((im >> 12) & 64'h1) << 31) | (((im >> 5) & 64'h3F) << 25) | (64'(s2) << 20)
                   | (64'(s1) << 15) | (((im >> 1) & 64'hF) << 8) | (((im >> 11) & 64'h1) << 7) | 64'h63;
            end
            default: ok = 1'b0;
        endcase
        return {ok, t[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [63:0] im);
        bus.in_valid = 1'b1; bus.in_kind = k; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
    endtask

    task automatic sreq(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [63:0] im);
        sbus.in_valid = 1'b1; sbus.in_kind = k; sbus.rd = d; sbus.rs1 = s1; sbus.rs2 = s2; sbus.imm = im;
    endtask

    task automatic do_flush();
        bus.in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 00000000", bus.instr); end
        n_checks++; if (bus.addr !== 64'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.addr); end
        n_checks++; if (sbus.addr !== SBASE) begin n_fail++; $display("FAIL rst_addr_base: got %h expected %h", sbus.addr, SBASE); end
        n_checks++; if ({bus.err, bus.full, bus.in_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_err_full_rdy: got %b expected 000", {bus.err, bus.full, bus.in_ready}); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_before_edge: got %b expected 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_after_edge: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_ld();
        do_flush();
        bus.out_ready = 1'b1;
        req(3'd0, 5'd10, 5'd6, 5'd0, 64'h36A);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid: got %b expected 1", bus.out_valid); end
        n_checks++; if (bus.instr !== 32'h36A33503) begin n_fail++; $display("FAIL ld_instr: got %h expected 36a33503", bus.instr); end
        n_checks++; if (bus.addr !== 64'h0) begin n_fail++; $display("FAIL ld_addr: got %h expected 0", bus.addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_flush();
        bus.out_ready = 1'b1;
        req(3'd2, 5'd10, 5'd6, 5'd10, 64'h0);
        tick();
        n_checks++; if (bus.instr !== 32'h00A30533 || bus.addr !== 64'h0) begin n_fail++; $display("FAIL b2b_add: got %h@%h expected 00a30533@0", bus.instr, bus.addr); end
        req(3'd3, 5'd10, 5'd6, 5'd10, 64'h0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.instr !== 32'h40A30533 || bus.addr !== 64'h4 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_sub: got %h@%h v%b expected 40a30533@4 v1", bus.instr, bus.addr, bus.out_valid); end
        tick();
    endtask

    task automatic test_beq();
        do_flush();
        bus.out_ready = 1'b1;
        req(3'd6, 5'd0, 5'd6, 5'd10, 64'd340);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.instr !== 32'h14A30A63 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL beq_instr: got %h v%b expected 14a30a63 v1", bus.instr, bus.out_valid); end
        tick();
    endtask

    task automatic test_reject();
        do_flush();
        bus.out_ready = 1'b1;
        req(3'd6, 5'd0, 5'd6, 5'd10, 64'd341);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rej_beq: got err%b v%b expected err1 v0", bus.err, bus.out_valid); end
        tick();
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rej_beq_pulse: got err%b expected err0", bus.err); end
        req(3'd0, 5'd1, 5'd2, 5'd0, 64'd2048);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rej_ld: got err%b v%b expected err1 v0", bus.err, bus.out_valid); end
        tick();
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rej_ld_pulse: got err%b expected err0", bus.err); end
        req(3'd2, 5'd1, 5'd2, 5'd3, 64'd0);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.addr !== 64'h0) begin n_fail++; $display("FAIL rej_next_addr: got v%b @%h expected v1 @0", bus.out_valid, bus.addr); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_flush();
        bus.out_ready = 1'b0;
        req(3'd2, 5'd1, 5'd2, 5'd3, 64'd0);
        tick();
        held = 32'h003100B3;
        req(3'd1, 5'd0, 5'd2, 5'd8, -64'sd8);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1 || bus.instr !== held || bus.addr !== 64'h0) begin n_fail++; $display("FAIL bp_hold: got v%b %h@%h expected v1 %h@0", bus.out_valid, bus.instr, bus.addr, held); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.instr !== 32'hFE813C23 || bus.addr !== 64'h4) begin n_fail++; $display("FAIL bp_next: got v%b %h@%h expected v1 fe813c23@4", bus.out_valid, bus.instr, bus.addr); end
        tick();
    endtask

    task automatic test_flush();
        do_flush();
        bus.out_ready = 1'b0;
        req(3'd4, 5'd5, 5'd6, 5'd7, 64'd0);
        tick();
        flush = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if ({bus.out_valid, bus.err, bus.full} !== 3'b000 || bus.addr !== 64'h0) begin n_fail++; $display("FAIL flush_state: got v/e/f %b @%h expected 000 @0", {bus.out_valid, bus.err, bus.full}, bus.addr); end
    endtask

    task automatic test_full();
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        sbus.out_ready = 1'b1;
        sreq(3'd2, 5'd1, 5'd2, 5'd3, 64'd0);
        tick();
        n_checks++; if (sbus.out_valid !== 1'b1 || sbus.addr !== SBASE) begin n_fail++; $display("FAIL full_w0: got v%b @%h expected v1 @%h", sbus.out_valid, sbus.addr, SBASE); end
        tick();
        n_checks++; if (sbus.addr !== SBASE + 64'd4 || sbus.full !== 1'b0) begin n_fail++; $display("FAIL full_w1: got @%h f%b expected @%h f0", sbus.addr, sbus.full, SBASE + 64'd4); end
        n_checks++; if (sbus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_last_ready: got %b expected 0", sbus.in_ready); end
        tick();
        n_checks++; if (sbus.full !== 1'b1 || sbus.out_valid !== 1'b0 || sbus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_done: got f%b v%b r%b expected f1 v0 r0", sbus.full, sbus.out_valid, sbus.in_ready); end
        tick();
        tick();
        n_checks++; if (sbus.full !== 1'b1 || sbus.err !== 1'b0 || sbus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_stall: got f%b e%b v%b expected f1 e0 v0", sbus.full, sbus.err, sbus.out_valid); end
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        #1;
        n_checks++; if (sbus.full !== 1'b0 || sbus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_flush: got f%b r%b expected f0 r1", sbus.full, sbus.in_ready); end
        tick();
        sbus.in_valid = 1'b0;
        n_checks++; if (sbus.out_valid !== 1'b1 || sbus.addr !== SBASE || sbus.instr !== 32'h003100B3) begin n_fail++; $display("FAIL full_restart: got v%b %h@%h expected v1 003100b3@%h", sbus.out_valid, sbus.instr, sbus.addr, SBASE); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_flush();
        bus.out_ready = 1'b0;
        req(3'd0, 5'd3, 5'd4, 5'd0, 64'd16);
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.out_valid, bus.err, bus.in_ready} !== 3'b000 || bus.instr !== 32'h0) begin n_fail++; $display("FAIL midrst_async: got v/e/r %b %h expected 000 00000000", {bus.out_valid, bus.err, bus.in_ready}, bus.instr); end
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if ({bus.out_valid, bus.err, bus.in_ready} !== 3'b001) begin n_fail++; $display("FAIL midrst_after: got v/e/r %b expected 001", {bus.out_valid, bus.err, bus.in_ready}); end
    endtask

    task automatic test_random();
        longint bnd [12] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 340, 341, -1};
        do_flush();
        m_valid = 1'b0; m_err = 1'b0; m_full = 1'b0; m_cnt = 0; m_instr = 32'h0; m_addr = 64'h0;
        for (int i = 0; i < 600; i++) begin
            logic        vld;
            logic        ordy;
            logic        fl;
            logic        exp_rdy;
            logic        acc;
            logic [2:0]  k;
            logic [4:0]  d;
            logic [4:0]  s1;
            logic [4:0]  s2;
            logic [63:0] im;
            logic [32:0] enc;
            longint      tmp;
            vld  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            k    = 3'($urandom_range(0, 7));
            d    = 5'($urandom);
            s1   = 5'($urandom);
            s2   = 5'($urandom);
            case ($urandom_range(0, 3))
                0: im = bnd[$urandom_range(0, 11)];
                1: begin tmp = longint'($urandom_range(0, 10000)); im = tmp - 5000; end
                2: im = {$urandom, $urandom};
                default: begin tmp = longint'($urandom_range(0, 255)); im = tmp * 2 - 256; end
            endcase
            bus.in_valid = vld; bus.in_kind = k; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
            bus.out_ready = ordy;
            flush = fl;
            #1;
            exp_rdy = !fl && !m_full && (!m_valid || ordy) && !(m_valid && m_cnt == MAXW - 1);
            n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_rdy); end
            acc = vld && exp_rdy;
            enc = ref_encode(k, d, s1, s2, im);
            tick();
            if (fl) begin
                m_valid = 1'b0; m_err = 1'b0; m_full = 1'b0; m_cnt = 0;
            end else begin
                m_err = acc && !enc[32];
                if (m_valid && ordy) begin
                    m_cnt++;
                    m_valid = 1'b0;
                end
                if (acc && enc[32]) begin
                    m_valid = 1'b1;
                    m_instr = enc[31:0];
                    m_addr  = 64'(m_cnt) * 64'd4;
                end
                if (m_cnt == MAXW) m_full = 1'b1;
            end
            n_checks++; if ({bus.out_valid, bus.err, bus.full} !== {m_valid, m_err, m_full}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got v/e/f %b expected %b", i, {bus.out_valid, bus.err, bus.full}, {m_valid, m_err, m_full}); end
            if (m_valid) begin
                n_checks++; if (bus.instr !== m_instr || bus.addr !== m_addr) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h@%h expected %h@%h", i, bus.instr, bus.addr, m_instr, m_addr); end
            end
        end
        bus.in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.imm = 64'h0; bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_kind = 3'd0; sbus.rd = 5'd0; sbus.rs1 = 5'd0; sbus.rs2 = 5'd0;
        sbus.imm = 64'h0; sbus.out_ready = 1'b0;
        test_reset();
        test_ld();
        test_back_to_back();
        test_beq();
        test_reject();
        test_backpressure();
        test_flush();
        test_full();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
